spi_reg_bank_rx: RTL and testbench

//  SPI-mode-0 write-only receiver and configuration register bank; feeds the PWM/output stage.

---
 rtl/spi_reg_bank_rx_pkg.sv | 19 +
 rtl/spi_reg_bank_rx_if.sv | 27 ++
 rtl/spi_reg_bank_rx_sync_ff.sv | 24 ++
 rtl/spi_reg_bank_rx.sv | 110 +++++++++++
 tb/tb_spi_reg_bank_rx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_bank_rx_pkg.sv
// Shared constants and FSM state type for the SPI write-only register bank.
// Register addresses, frame length and the receiver state enum.
package spi_reg_pkg;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned NUM_REGS   = 5;

   localparam logic [6:0] ADDR_OUT_LO = 7'd0;
   localparam logic [6:0] ADDR_OUT_HI = 7'd1;
   localparam logic [6:0] ADDR_PWM_LO = 7'd2;
   localparam logic [6:0] ADDR_PWM_HI = 7'd3;
   localparam logic [6:0] ADDR_DUTY   = 7'd4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/spi_reg_bank_rx_if.sv
// SPI pin and register-output bundle between the pads, the receiver and the PWM stage.
interface spi_reg_bank_rx_if;

   logic       nCS;
   logic       SCLK;
   logic       COPI;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic       wr_strobe;
   logic       frame_err;

   modport master (
      output nCS, SCLK, COPI,
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
      input  pwm_duty_cycle, wr_strobe, frame_err
   );

   modport slave (
      input  nCS, SCLK, COPI,
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
      output pwm_duty_cycle, wr_strobe, frame_err
   );

endinterface

// File: rtl/spi_reg_bank_rx_sync_ff.sv
// Multi-flop synchronizer for one asynchronous pin, with a configurable reset value.
module sync_ff #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff_q <= {STAGES{RST_VAL}};
      end else begin
         ff_q <= {ff_q[STAGES-2:0], d};
      end
   end

   assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bank_rx.sv
// SPI mode-0 write-only receiver: synchronizes the pins, shifts 16-bit frames and
// commits valid writes into five 8-bit control registers.
module spi_reg_bank_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_BITS  = 16,
   parameter int unsigned MAX_ADDR    = 4
) (
   input logic             clk,
   input logic             rst,
   spi_reg_bank_rx_if.slave bus
);

   import spi_reg_pkg::*;

   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

   logic ncs_s, sclk_s, copi_s;
   logic ncs_q, sclk_q;
   logic ncs_fall, ncs_rise, sclk_rise;

   state_e                state_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic [4:0]            cnt_q;
   logic [7:0]            regs_q [NUM_REGS];
   logic                  wr_strobe_q, frame_err_q;

   logic       evaluate, frame_ok, addr_ok, rw, do_write;
   logic [6:0] addr;
   logic [7:0] data;

   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .d(bus.nCS), .q(ncs_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(bus.SCLK), .q(sclk_s)
   );
   sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .d(bus.COPI), .q(copi_s)
   );

   always_comb begin
      ncs_fall  = ncs_q & ~ncs_s;
      ncs_rise  = ~ncs_q & ncs_s;
      sclk_rise = ~sclk_q & sclk_s;
      rw        = shift_q[FRAME_BITS-1];
      addr      = shift_q[FRAME_BITS-2 -: 7];
      data      = shift_q[7:0];
      evaluate  = (state_q == SHIFT) && ncs_rise;
      frame_ok  = (cnt_q == CNT_FULL);
      addr_ok   = ({25'd0, addr} <= MAX_ADDR);
      do_write  = evaluate && frame_ok && rw && addr_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ncs_q       <= 1'b1;
         sclk_q      <= 1'b0;
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         wr_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         ncs_q       <= ncs_s;
         sclk_q      <= sclk_s;
         wr_strobe_q <= do_write;
         frame_err_q <= evaluate && !frame_ok;
         if (do_write) begin
            case (addr)
               ADDR_OUT_LO: regs_q[0] <= data;
               ADDR_OUT_HI: regs_q[1] <= data;
               ADDR_PWM_LO: regs_q[2] <= data;
               ADDR_PWM_HI: regs_q[3] <= data;
               ADDR_DUTY:   regs_q[4] <= data;
               default: ;
            endcase
         end
         case (state_q)
            IDLE: begin
               if (ncs_fall) begin
                  state_q <= SHIFT;
                  shift_q <= '0;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (ncs_rise) begin
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
                  // Saturate so long frames stay distinguishable from exact ones.
                  if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 5'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.en_reg_out_7_0  = regs_q[0];
   assign bus.en_reg_out_15_8 = regs_q[1];
   assign bus.en_reg_pwm_7_0  = regs_q[2];
   assign bus.en_reg_pwm_15_8 = regs_q[3];
   assign bus.pwm_duty_cycle  = regs_q[4];
   assign bus.wr_strobe       = wr_strobe_q;
   assign bus.frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank_rx.sv
// Self-checking bench for spi_reg_bank_rx: directed scenarios plus random frames
// compared against a frame-level register model.
module tb_spi_reg_bank_rx;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_reg_bank_rx_if bus ();

   spi_reg_bank_rx #(
      .SYNC_STAGES(2),
      .FRAME_BITS (16),
      .MAX_ADDR   (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_regs [5];
   logic [7:0] dut_regs [5];
   int   exp_strobes = 0, exp_errs = 0;
   int   obs_strobes = 0, obs_errs = 0;
   logic settled     = 1'b0;
   logic prev_strobe = 1'b0, prev_err = 1'b0;

   assign dut_regs[0] = bus.en_reg_out_7_0;
   assign dut_regs[1] = bus.en_reg_out_15_8;
   assign dut_regs[2] = bus.en_reg_pwm_7_0;
   assign dut_regs[3] = bus.en_reg_pwm_15_8;
   assign dut_regs[4] = bus.pwm_duty_cycle;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame-level model: only complete 16-bit writes to an implemented address land.
   task automatic model_frame(input logic [31:0] v, input int nbits);
      if (nbits == 16) begin
         if (v[15] && v[14:8] <= 7'd4) begin
            exp_regs[v[10:8]] = v[7:0];
            exp_strobes++;
         end
      end else begin
         exp_errs++;
      end
   endtask

   task automatic send_frame(input logic [31:0] v, input int nbits, input int gap);
      bus.nCS = 1'b0;
      tick(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.COPI = v[i];
         tick(4);
         bus.SCLK = 1'b1;
         tick(4);
         bus.SCLK = 1'b0;
      end
      tick(2);
      bus.nCS = 1'b1;
      model_frame(v, nbits);
      tick(gap);
   endtask

   task automatic do_frame(input logic [31:0] v, input int nbits, input int gap);
      settled = 1'b0;
      send_frame(v, nbits, gap);
      tick(10);
      settled = 1'b1;
      chk("strobe_count", obs_strobes, exp_strobes);
      chk("err_count", obs_errs, exp_errs);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (rst) begin
         prev_strobe = 1'b0;
         prev_err    = 1'b0;
      end else begin
         if (bus.wr_strobe) begin
            obs_strobes++;
            chk("wr_strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
         end
         if (bus.frame_err) begin
            obs_errs++;
            chk("frame_err_one_cycle", {31'd0, prev_err}, 32'd0);
         end
         prev_strobe = bus.wr_strobe;
         prev_err    = bus.frame_err;
         if (settled) begin
            for (int i = 0; i < 5; i++) chk($sformatf("reg%0d", i), dut_regs[i], exp_regs[i]);
            chk("idle_strobe", {31'd0, bus.wr_strobe}, 32'd0);
            chk("idle_err", {31'd0, bus.frame_err}, 32'd0);
         end
      end
   end

   initial begin
      bus.nCS  = 1'b1;
      bus.SCLK = 1'b0;
      bus.COPI = 1'b0;
      for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
      tick(5);
      rst = 1'b0;
      tick(3);
      settled = 1'b1;
      tick(2);
      chk("reset_out_lo", bus.en_reg_out_7_0, 32'h00);
      chk("reset_duty", bus.pwm_duty_cycle, 32'h00);

      // 1: simple write to addr 0
      do_frame(32'h80F0, 16, 4);
      chk("t1_out_lo", bus.en_reg_out_7_0, 32'hF0);
      chk("t1_out_hi", bus.en_reg_out_15_8, 32'h00);
      chk("t1_strobes", obs_strobes, 32'd1);

      // 2: write then read to duty
      do_frame(32'h8480, 16, 4);
      do_frame(32'h04FF, 16, 4);
      chk("t2_duty", bus.pwm_duty_cycle, 32'h80);
      chk("t2_strobes", obs_strobes, 32'd2);

      // 3: unimplemented address
      do_frame(32'h85AA, 16, 4);
      chk("t3_strobes", obs_strobes, 32'd2);
      chk("t3_errs", obs_errs, 32'd0);

      // 4: short and long frames, plus an nCS glitch
      do_frame(32'h8233 >> 1, 15, 4);
      do_frame({15'd0, 17'h8233 << 1}, 17, 4);
      chk("t4_pwm_lo", bus.en_reg_pwm_7_0, 32'h00);
      chk("t4_errs", obs_errs, 32'd2);
      do_frame(32'h0, 0, 4);
      chk("glitch_errs", obs_errs, 32'd3);

      // 5: preload 0xFF, reset mid-frame, then a clean write
      for (int a = 0; a < 5; a++) do_frame(32'h80FF | (a << 8), 16, 4);
      chk("t5_preload", bus.en_reg_pwm_15_8, 32'hFF);
      settled = 1'b0;
      bus.nCS = 1'b0;
      tick(4);
      for (int i = 15; i >= 8; i--) begin
         bus.COPI = 1'(32'h8355 >> i);
         tick(4);
         bus.SCLK = 1'b1;
         tick(4);
         bus.SCLK = 1'b0;
      end
      rst = 1'b1;
      tick(2);
      bus.nCS = 1'b1;
      tick(3);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
      tick(5);
      settled = 1'b1;
      tick(1);
      chk("t5_reset_out_lo", bus.en_reg_out_7_0, 32'h00);
      chk("t5_reset_duty", bus.pwm_duty_cycle, 32'h00);
      do_frame(32'h8355, 16, 4);
      chk("t5_pwm_hi", bus.en_reg_pwm_15_8, 32'h55);

      // 6: back-to-back burst with a minimal nCS gap
      settled = 1'b0;
      for (int a = 0; a < 5; a++) send_frame(32'h8000 | (a << 8) | ((a + 1) * 32'h11), 16, 2);
      tick(10);
      settled = 1'b1;
      chk("t6_strobes", obs_strobes, exp_strobes);
      chk("t6_out_lo", bus.en_reg_out_7_0, 32'h11);
      chk("t6_duty", bus.pwm_duty_cycle, 32'h55);

      // Random frames
      for (int n = 0; n < 40; n++) begin
         logic [31:0] v;
         int nb;
         v = $urandom;
         v[14:8] = 7'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) v[14:8] = 7'($urandom_range(0, 127));
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : 16;
         do_frame(v, nb, int'($urandom_range(2, 6)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
